lc4_regfile_2w: RTL and testbench

Parametrised two-write, four-read register file for the two-way superscalar LC4 pipeline. Pipe A is the older instruction and pipe B the younger; the pipes share one architectural register array. Each pipe gets rs/rt read ports and an rd write port. Same-cycle write data is bypassed into all read ports, and on a same-register write conflict the younger pipe (B) wins. It sits in decode (reads) and writeback (writes), replacing the single-issue register file.

---
 rtl/lc4_regfile_2w_pkg.sv | 11 +
 rtl/Nbit_reg.sv | 24 ++
 rtl/lc4_regfile_rdport.sv | 45 ++++
 rtl/lc4_regfile_2w.sv | 79 +++++++
 tb/tb_lc4_regfile_2w.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/lc4_regfile_2w_pkg.sv
// Shared types for the two-write LC4 register file.
// A read port picks one of these sources to drive its output.
package lc4_regfile_2w_pkg;

  typedef enum logic [1:0] {
    SRC_REG = 2'd0,
    SRC_A   = 2'd1,
    SRC_B   = 2'd2
  } rd_src_e;

endpackage

// File: rtl/Nbit_reg.sv
// n-bit register with write enable, gated by global write enable; sync active-high reset.
// One-cycle latency; the register holds its value whenever gwe is low.
module Nbit_reg #(
  parameter int n = 16
) (
  input  logic         clk,
  input  logic         we,
  input  logic         gwe,
  input  logic         rst,
  input  logic [n-1:0] in,
  output logic [n-1:0] out
);

  always_ff @(posedge clk) begin
    if (gwe) begin
      if (rst) begin
        out <= '0;
      end else if (we) begin
        out <= in;
      end
    end
  end

endmodule

// File: rtl/lc4_regfile_rdport.sv
// One combinational read port: R:1 register mux followed by a pipe-B/pipe-A bypass.
// Zero latency; no flow control.
module lc4_regfile_rdport
  import lc4_regfile_2w_pkg::*;
#(
  parameter int n = 16,
  parameter int a = 3
) (
  input  logic [(2**a)*n-1:0] i_regs,
  input  logic [a-1:0]        i_sel,
  input  logic                i_rst,
  input  logic [a-1:0]        i_rd_a,
  input  logic [n-1:0]        i_wdata_a,
  input  logic                i_rd_we_a,
  input  logic [a-1:0]        i_rd_b,
  input  logic [n-1:0]        i_wdata_b,
  input  logic                i_rd_we_b,
  output logic [n-1:0]        o_data
);

  rd_src_e      w_src;
  logic [n-1:0] w_stored;

  assign w_stored = i_regs[i_sel*n +: n];

  // Pipe B is younger, so its in-flight value shadows pipe A's.
  always_comb begin
    w_src = SRC_REG;
    if (!i_rst && i_rd_we_b && (i_rd_b == i_sel)) begin
      w_src = SRC_B;
    end else if (!i_rst && i_rd_we_a && (i_rd_a == i_sel)) begin
      w_src = SRC_A;
    end
  end

  always_comb begin
    o_data = w_stored;
    case (w_src)
      SRC_B:   o_data = i_wdata_b;
      SRC_A:   o_data = i_wdata_a;
      default: o_data = w_stored;
    endcase
  end

endmodule

// File: rtl/lc4_regfile_2w.sv
// Two-write, four-read LC4 register file; pipe B wins write conflicts.
// Reads are combinational with same-cycle write bypass; writes land on the next edge when gwe=1.
module lc4_regfile_2w
  import lc4_regfile_2w_pkg::*;
#(
  parameter int n = 16,
  parameter int a = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         gwe,
  input  logic [a-1:0] i_rs_a,
  input  logic [a-1:0] i_rt_a,
  input  logic [a-1:0] i_rs_b,
  input  logic [a-1:0] i_rt_b,
  output logic [n-1:0] o_rs_data_a,
  output logic [n-1:0] o_rt_data_a,
  output logic [n-1:0] o_rs_data_b,
  output logic [n-1:0] o_rt_data_b,
  input  logic [a-1:0] i_rd_a,
  input  logic [a-1:0] i_rd_b,
  input  logic [n-1:0] i_wdata_a,
  input  logic [n-1:0] i_wdata_b,
  input  logic         i_rd_we_a,
  input  logic         i_rd_we_b
);

  localparam int R = 2**a;

  logic [R*n-1:0] w_regs;

  for (genvar k = 0; k < R; k++) begin : g_reg
    logic         w_hit_a;
    logic         w_hit_b;
    logic [n-1:0] w_in;

    assign w_hit_a = i_rd_we_a && (i_rd_a == a'(k));
    assign w_hit_b = i_rd_we_b && (i_rd_b == a'(k));
    assign w_in    = w_hit_b ? i_wdata_b : i_wdata_a;

    Nbit_reg #(.n(n)) u_reg (
      .clk (clk),
      .we  (w_hit_a | w_hit_b),
      .gwe (gwe),
      .rst (rst),
      .in  (w_in),
      .out (w_regs[k*n +: n])
    );
  end

  logic [a-1:0] w_sel [4];
  logic [n-1:0] w_out [4];

  assign w_sel[0] = i_rs_a;
  assign w_sel[1] = i_rt_a;
  assign w_sel[2] = i_rs_b;
  assign w_sel[3] = i_rt_b;

  for (genvar p = 0; p < 4; p++) begin : g_port
    lc4_regfile_rdport #(.n(n), .a(a)) u_port (
      .i_regs    (w_regs),
      .i_sel     (w_sel[p]),
      .i_rst     (rst),
      .i_rd_a    (i_rd_a),
      .i_wdata_a (i_wdata_a),
      .i_rd_we_a (i_rd_we_a),
      .i_rd_b    (i_rd_b),
      .i_wdata_b (i_wdata_b),
      .i_rd_we_b (i_rd_we_b),
      .o_data    (w_out[p])
    );
  end

  assign o_rs_data_a = w_out[0];
  assign o_rt_data_a = w_out[1];
  assign o_rs_data_b = w_out[2];
  assign o_rt_data_b = w_out[3];

endmodule

// File: tb/tb_lc4_regfile_2w.sv
// Scoreboard bench for lc4_regfile_2w: a register-array model predicts every read port,
// expectations are queued by the stimulus and popped by a negedge monitor.
module tb_lc4_regfile_2w;
  localparam int N = 16;
  localparam int A = 3;
  localparam int R = 1 << A;

  logic         clk = 1'b0;
  logic         rst, gwe;
  logic [A-1:0] rs_a, rt_a, rs_b, rt_b, rd_a, rd_b;
  logic [N-1:0] wd_a, wd_b;
  logic         we_a, we_b;
  logic [N-1:0] o_rs_a, o_rt_a, o_rs_b, o_rt_b;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int           port;
    logic [N-1:0] exp;
  } exp_t;
  exp_t sb_q[$];

  logic [N-1:0] model [R];

  always #5 clk = ~clk;

  lc4_regfile_2w #(.n(N), .a(A)) dut (
    .clk(clk), .rst(rst), .gwe(gwe),
    .i_rs_a(rs_a), .i_rt_a(rt_a), .i_rs_b(rs_b), .i_rt_b(rt_b),
    .o_rs_data_a(o_rs_a), .o_rt_data_a(o_rt_a),
    .o_rs_data_b(o_rs_b), .o_rt_data_b(o_rt_b),
    .i_rd_a(rd_a), .i_rd_b(rd_b), .i_wdata_a(wd_a), .i_wdata_b(wd_b),
    .i_rd_we_a(we_a), .i_rd_we_b(we_b)
  );

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected read value derived from the architectural rules, not the RTL structure.
  function automatic logic [N-1:0] predict(input logic [A-1:0] sel);
    if (!rst && we_b && rd_b == sel) return wd_b;
    if (!rst && we_a && rd_a == sel) return wd_a;
    return model[sel];
  endfunction

  // Drive one cycle's inputs; expectations are queued once they settle.
  task automatic drive(input logic r, input logic g,
                       input logic [A-1:0] s0, input logic [A-1:0] s1,
                       input logic [A-1:0] s2, input logic [A-1:0] s3,
                       input logic ea, input logic [A-1:0] da, input logic [N-1:0] va,
                       input logic eb, input logic [A-1:0] db, input logic [N-1:0] vb);
    rst = r; gwe = g;
    rs_a = s0; rt_a = s1; rs_b = s2; rt_b = s3;
    we_a = ea; rd_a = da; wd_a = va;
    we_b = eb; rd_b = db; wd_b = vb;
    #1;
    sb_q.push_back('{0, predict(rs_a)});
    sb_q.push_back('{1, predict(rt_a)});
    sb_q.push_back('{2, predict(rs_b)});
    sb_q.push_back('{3, predict(rt_b)});
  endtask

  task automatic step();
    @(posedge clk);
    if (gwe) begin
      if (rst) begin
        for (int k = 0; k < R; k++) model[k] = '0;
      end else begin
        if (we_a) model[rd_a] = wd_a;
        if (we_b) model[rd_b] = wd_b;
      end
    end
    #1;
  endtask

  task automatic read_all(input logic [A-1:0] k);
    drive(0, 1, k, k, k, k, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      logic [N-1:0] act;
      e = sb_q.pop_front();
      case (e.port)
        0:       act = o_rs_a;
        1:       act = o_rt_a;
        2:       act = o_rs_b;
        default: act = o_rt_b;
      endcase
      chk($sformatf("port%0d", e.port), act, e.exp);
    end
  end

  initial begin
    // Initial reset: stored values are unknown until this edge, so nothing is queued.
    rst = 1; gwe = 1;
    rs_a = 0; rt_a = 0; rs_b = 0; rt_b = 0;
    rd_a = 0; rd_b = 0; wd_a = 0; wd_b = 0; we_a = 0; we_b = 0;
    @(posedge clk);
    for (int k = 0; k < R; k++) model[k] = '0;
    #1;
    read_all(0);
    chk("reset_r0", o_rs_a, 16'h0000);

    // Reset clears a written register on every port.
    drive(0, 1, 0, 0, 0, 0, 1, 5, 16'h1234, 0, 0, 0); step();
    read_all(5);
    chk("pre_reset_r5", o_rt_b, 16'h1234);
    drive(1, 1, 5, 5, 5, 5, 0, 0, 0, 0, 0, 0); step();
    for (int k = 0; k < R; k++) read_all(A'(k));
    drive(0, 1, 5, 5, 5, 5, 0, 0, 0, 0, 0, 0);
    chk("post_reset_r5", o_rs_b, 16'h0000);
    step();

    // Reset with gwe low has no effect.
    drive(0, 1, 0, 0, 0, 0, 1, 5, 16'h1234, 0, 0, 0); step();
    drive(1, 0, 5, 5, 5, 5, 0, 0, 0, 0, 0, 0); step();
    drive(0, 1, 5, 5, 5, 5, 0, 0, 0, 0, 0, 0);
    chk("reset_gwe0_r5", o_rs_a, 16'h1234);
    step();

    // Same-cycle bypass from pipe A.
    drive(0, 1, 0, 0, 3, 0, 1, 3, 16'hBEEF, 0, 0, 0);
    chk("bypass_a", o_rs_b, 16'hBEEF);
    step();
    drive(0, 1, 3, 3, 3, 3, 0, 0, 0, 0, 0, 0);
    chk("stored_r3", o_rt_a, 16'hBEEF);
    step();

    // WAW: pipe B wins.
    drive(0, 1, 2, 2, 2, 2, 1, 2, 16'h1111, 1, 2, 16'h2222);
    chk("waw_bypass", o_rs_a, 16'h2222);
    step();
    drive(0, 1, 2, 2, 2, 2, 0, 0, 0, 0, 0, 0);
    chk("waw_stored", o_rt_b, 16'h2222);
    step();

    // Dual distinct writes.
    drive(0, 1, 1, 1, 1, 1, 1, 0, 16'h00FF, 1, 7, 16'hFF00); step();
    drive(0, 1, 0, 3, 2, 7, 0, 0, 0, 0, 0, 0);
    chk("dual_r0", o_rs_a, 16'h00FF);
    chk("dual_r7", o_rt_b, 16'hFF00);
    chk("dual_r3_kept", o_rt_a, 16'hBEEF);
    step();

    // Stall: bypass visible, no state change.
    drive(0, 1, 0, 0, 0, 0, 1, 4, 16'h0001, 0, 0, 0); step();
    drive(0, 0, 4, 4, 4, 4, 1, 4, 16'hAAAA, 0, 0, 0);
    chk("stall_bypass", o_rs_a, 16'hAAAA);
    step();
    drive(0, 1, 4, 4, 4, 4, 0, 0, 0, 0, 0, 0);
    chk("stall_kept", o_rt_a, 16'h0001);
    step();

    // Reset beats write; bypass suppressed during reset.
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 6, 16'h7777); step();
    drive(1, 1, 0, 6, 0, 0, 0, 0, 0, 1, 6, 16'h5555);
    chk("rst_no_bypass", o_rt_a, 16'h7777);
    step();
    drive(0, 1, 6, 6, 6, 6, 0, 0, 0, 0, 0, 0);
    chk("rst_beats_write", o_rs_a, 16'h0000);
    step();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
            A'($urandom), A'($urandom), A'($urandom), A'($urandom),
            1'($urandom), A'($urandom), N'($urandom),
            1'($urandom), A'($urandom), N'($urandom));
      step();
    end

    begin
      int budget = 0;
      while (sb_q.size() > 0 && budget < 20) begin
        @(posedge clk);
        budget++;
      end
      if (sb_q.size() > 0) chk("drain_timeout", N'(sb_q.size()), '0);
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
